// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the I2S audio transmitter.
//   audio_sample_t     : signed 16-bit PCM sample
//   AUDIO_SLOTS_PER_CH : bclk slots per channel (32)
//   AUDIO_FRAME_BCLKS  : bclk periods per frame (64)
//   bit_idx_t          : frame bit position 0..63
//   slot_kind()        : classifies a frame position as left data, right data
//                        or padding, including the one-slot I2S delay
//   sat_inc()          : saturating 16-bit increment
// -----------------------------------------------------------------------------
package audio_pkg;

  typedef logic signed [15:0] audio_sample_t;

  localparam int AUDIO_SLOTS_PER_CH = 32;
  localparam int AUDIO_FRAME_BCLKS  = 64;
  localparam int AUDIO_BIT_W        = 6;
  localparam int AUDIO_SAMPLE_W     = 16;

  typedef logic [AUDIO_BIT_W-1:0] bit_idx_t;

  typedef enum logic [1:0] {
    SLOT_PAD   = 2'd0,
    SLOT_LEFT  = 2'd1,
    SLOT_RIGHT = 2'd2
  } slot_kind_t;

  localparam bit_idx_t LEFT_FIRST  = bit_idx_t'(1);
  localparam bit_idx_t LEFT_LAST   = bit_idx_t'(AUDIO_SAMPLE_W);
  localparam bit_idx_t RIGHT_FIRST = bit_idx_t'(AUDIO_SLOTS_PER_CH + 1);
  localparam bit_idx_t RIGHT_LAST  = bit_idx_t'(AUDIO_SLOTS_PER_CH + AUDIO_SAMPLE_W);

  // Each channel's MSB sits one slot after its lrclk edge, so data occupies
  // positions 1..16 (left) and 33..48 (right); everything else is padding.
  function automatic slot_kind_t slot_kind(input bit_idx_t idx);
    slot_kind_t kind;
    if (idx >= LEFT_FIRST && idx <= LEFT_LAST) begin
      kind = SLOT_LEFT;
    end else if (idx >= RIGHT_FIRST && idx <= RIGHT_LAST) begin
      kind = SLOT_RIGHT;
    end else begin
      kind = SLOT_PAD;
    end
    return kind;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/audio_i2s_clkgen.sv
// -----------------------------------------------------------------------------
// audio_i2s_clkgen
// Bit clock / word select generator and frame bit counter.
//   clk, reset : system clock, synchronous active-high reset
//   bclk       : bit clock, toggles every BCLK_DIV clk cycles
//   lrclk      : word select (0 = left, 1 = right), changes with bclk falling
//   fall       : single-cycle strobe, high on the clk edge where bclk goes 1->0
//   load       : fall strobe of the 63->0 wrap (frame load point)
//   bit_idx    : current frame position 0..63
// -----------------------------------------------------------------------------
module audio_i2s_clkgen
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic     clk,
  input  logic     reset,
  output logic     bclk,
  output logic     lrclk,
  output logic     fall,
  output logic     load,
  output bit_idx_t bit_idx
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);
  localparam bit_idx_t   IDX_LAST = bit_idx_t'(AUDIO_FRAME_BCLKS - 1);

  logic [7:0] div;
  logic       half_done;
  bit_idx_t   next_idx;

  assign half_done = (div == DIV_LAST);
  assign fall      = half_done & bclk;
  assign load      = fall & (bit_idx == IDX_LAST);
  assign next_idx  = bit_idx + bit_idx_t'(1);

  // Divider, bit clock, word select and frame position
  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= 8'd0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      bit_idx <= '0;
    end else begin
      if (half_done) begin
        div  <= 8'd0;
        bclk <= ~bclk;
      end else begin
        div  <= div + 8'd1;
      end
      if (fall) begin
        // 64-position frame wraps naturally in 6 bits; upper half is right
        bit_idx <= next_idx;
        lrclk   <= next_idx[AUDIO_BIT_W-1];
      end
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
// Standard I2S transmitter: 64 bclk frame, 16-bit samples MSB-first in a
// 32-slot channel, data delayed one bclk after the lrclk edge. A one-deep
// holding register decouples the sample strobe from the frame; at the frame
// load point the holding sample (or the previous one, on underrun) moves to
// the shift registers.
//   clk, reset      : system clock, synchronous active-high reset
//   audio_l/audio_r : signed samples, qualified by sample_valid
//   sample_ready    : holding register empty
//   i2s_bclk, i2s_lrclk, i2s_sdata : I2S serial outputs
//   underrun_cnt    : saturating count of frames reloaded from previous sample
//   overrun_cnt     : saturating count of strobes dropped while holding full
// Build option: define AUDIO_I2S_TX_STATS_EN to include the two counters;
// without it both count ports are tied to zero.
// -----------------------------------------------------------------------------
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic [15:0] underrun_cnt,
  output logic [15:0] overrun_cnt
);

  audio_sample_t hold_l, hold_r;
  audio_sample_t shift_l, shift_r;
  audio_sample_t prev_l, prev_r;
  logic          fall, load;
  bit_idx_t      bit_idx, next_idx;

  audio_i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .clk     (clk),
    .reset   (reset),
    .bclk    (i2s_bclk),
    .lrclk   (i2s_lrclk),
    .fall    (fall),
    .load    (load),
    .bit_idx (bit_idx)
  );

  assign next_idx = bit_idx + bit_idx_t'(1);

  // Shift registers and serial data, updated only on bclk falling edges
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_l   <= '0;
      shift_r   <= '0;
      i2s_sdata <= 1'b0;
    end else if (load) begin
      // empty holding register means underrun: repeat the last frame
      if (sample_ready) begin
        shift_l <= prev_l;
        shift_r <= prev_r;
      end else begin
        shift_l <= hold_l;
        shift_r <= hold_r;
      end
      i2s_sdata <= 1'b0;
    end else if (fall) begin
      case (slot_kind(next_idx))
        SLOT_LEFT: begin
          i2s_sdata <= shift_l[15];
          shift_l   <= {shift_l[14:0], 1'b0};
        end
        SLOT_RIGHT: begin
          i2s_sdata <= shift_r[15];
          shift_r   <= {shift_r[14:0], 1'b0};
        end
        default: begin
          i2s_sdata <= 1'b0;
        end
      endcase
    end else begin
      i2s_sdata <= i2s_sdata;
    end
  end

  // Holding register, previous-sample copy and ready flag
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_l       <= '0;
      hold_r       <= '0;
      prev_l       <= '0;
      prev_r       <= '0;
      sample_ready <= 1'b1;
    end else if (load) begin
      if (!sample_ready) begin
        prev_l <= hold_l;
        prev_r <= hold_r;
      end
      // a strobe in the load cycle lands after the transfer, never an overrun
      if (sample_valid) begin
        hold_l       <= audio_l;
        hold_r       <= audio_r;
        sample_ready <= 1'b0;
      end else begin
        sample_ready <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      hold_l       <= audio_l;
      hold_r       <= audio_r;
      sample_ready <= 1'b0;
    end else begin
      sample_ready <= sample_ready;
    end
  end

`ifdef AUDIO_I2S_TX_STATS_EN
  logic [15:0] underrun_total, overrun_total;

  // Saturating underrun / overrun statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_total <= 16'd0;
      overrun_total  <= 16'd0;
    end else begin
      if (load && sample_ready) begin
        underrun_total <= sat_inc(underrun_total);
      end
      if (!load && sample_valid && !sample_ready) begin
        overrun_total <= sat_inc(overrun_total);
      end
    end
  end

  assign underrun_cnt = underrun_total;
  assign overrun_cnt  = overrun_total;
`else
  assign underrun_cnt = 16'd0;
  assign overrun_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_audio_i2s_tx
// Directed bench for audio_i2s_tx (BCLK_DIV = 4, 40 ns clk). Stimulus pushes
// the expected {left,right} word of every frame into a queue; an independent
// monitor deserialises the I2S stream and compares each completed frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_audio_i2s_tx;

`ifdef AUDIO_I2S_TX_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] audio_l, audio_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata;
  logic [15:0] underrun_cnt, overrun_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  time         t1, t2;

  audio_i2s_tx #(.BCLK_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .audio_l      (audio_l),
    .audio_r      (audio_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Wait (bounded) for bclk or lrclk to reach lvl; returns time of detection.
  task automatic wait_edge(input bit use_lr, input logic lvl, output time t);
    logic prev, cur;
    bit   found;
    found = 1'b0;
    prev  = use_lr ? i2s_lrclk : i2s_bclk;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      cur = use_lr ? i2s_lrclk : i2s_bclk;
      if (cur == lvl && prev != lvl) found = 1'b1;
      prev = cur;
    end
    t = $time;
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_timeout: sel %0d level %0d not seen", use_lr, lvl);
    end
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    sample_valid = 1'b1;
    audio_l      = l;
    audio_r      = r;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Monitor: deserialise at bclk rising edges, compare each full frame
  initial begin
    int          pos;
    logic        cur_lr, prev_bclk, pad_bad;
    logic [15:0] wl, wr;
    logic [31:0] exp;
    pos = -1; cur_lr = 1'b0; prev_bclk = 1'b0; pad_bad = 1'b0; wl = 16'd0; wr = 16'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pos = -1; cur_lr = 1'b0; prev_bclk = 1'b0; pad_bad = 1'b0; wl = 16'd0; wr = 16'd0;
      end else begin
        if (i2s_bclk && !prev_bclk) begin
          if (i2s_lrclk != cur_lr) begin
            check("chan_len", 32'(pos), 32'd31);
            cur_lr = i2s_lrclk;
            pos    = 0;
          end else begin
            pos++;
          end
          if (pos >= 1 && pos <= 16) begin
            if (cur_lr) wr = {wr[14:0], i2s_sdata};
            else        wl = {wl[14:0], i2s_sdata};
          end else if (i2s_sdata) begin
            pad_bad = 1'b1;
          end
          if (cur_lr && pos == 16) begin
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL sb_empty: frame %h with no expectation", {wl, wr});
            end else begin
              exp = sb.pop_front();
              check("frame", {wl, wr}, exp);
              check("frame_pad", 32'(pad_bad), 32'd0);
            end
            pad_bad = 1'b0;
          end
        end
        prev_bclk = i2s_bclk;
      end
    end
  end

  // Stimulus
  initial begin
    int k;
    reset = 1'b1; sample_valid = 1'b0; audio_l = 16'd0; audio_r = 16'd0;
    repeat (5) @(negedge clk);
    check("rst_bclk",     32'(i2s_bclk),     32'd0);
    check("rst_lrclk",    32'(i2s_lrclk),    32'd0);
    check("rst_sdata",    32'(i2s_sdata),    32'd0);
    check("rst_ready",    32'(sample_ready), 32'd1);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    check("rst_overrun",  32'(overrun_cnt),  32'd0);
    reset = 1'b0;
    sb.push_back(32'h0000_0000);               // frame 0: nothing loaded yet

    // Single sample, then three frames with no new sample
    repeat (3) @(negedge clk);
    strobe(16'h8001, 16'h7FFE);
    check("ready_clear", 32'(sample_ready), 32'd0);
    repeat (4) sb.push_back(32'h8001_7FFE);    // frame 1 + three repeats

    wait_edge(1'b0, 1'b1, t1);
    wait_edge(1'b0, 1'b1, t2);
    check("bclk_period", 32'(t2 - t1), 32'd320);
    wait_edge(1'b1, 1'b1, t1);
    wait_edge(1'b1, 1'b1, t2);
    check("lrclk_period", 32'(t2 - t1), 32'd20480);

    wait_edge(1'b1, 1'b0, t1);                 // load 2
    check("ready_after_load", 32'(sample_ready), 32'd1);
    wait_edge(1'b1, 1'b0, t1);                 // load 3
    wait_edge(1'b1, 1'b0, t1);                 // load 4
    check("underrun_3", 32'(underrun_cnt), 32'(3 * STATS));

    // Two back-to-back strobes: second one is dropped
    sample_valid = 1'b1; audio_l = 16'h1234; audio_r = 16'hABCD;
    @(negedge clk);
    audio_l = 16'h5555; audio_r = 16'hAAAA;
    @(negedge clk);
    sample_valid = 1'b0;
    sb.push_back(32'h1234_ABCD);               // frame 5
    check("ovr_ready", 32'(sample_ready), 32'd0);
    check("overrun_1", 32'(overrun_cnt),  32'(STATS));

    // Strobe landing exactly on the load-point cycle
    wait_edge(1'b1, 1'b0, t1);                 // load 5
    strobe(16'h0F0F, 16'hF0F0);
    sb.push_back(32'h0F0F_F0F0);               // frame 6
    repeat (510) @(negedge clk);
    check("pre_load_lr", 32'(i2s_lrclk), 32'd1);
    sample_valid = 1'b1; audio_l = 16'h7FFF; audio_r = 16'h8000;
    @(negedge clk);
    sample_valid = 1'b0;
    sb.push_back(32'h7FFF_8000);               // frame 7
    check("load_align", 32'(i2s_lrclk), 32'd0);
    check("lp_ready", 32'(sample_ready), 32'd0);
    check("lp_overrun", 32'(overrun_cnt), 32'(STATS));

    // Reset pulse at bit 40 with a sample pending in holding
    wait_edge(1'b1, 1'b0, t1);                 // load 7
    check("ready_load7", 32'(sample_ready), 32'd1);
    strobe(16'h1111, 16'h2222);
    repeat (324) @(negedge clk);
    sb.delete();                               // frame 7 is cut short
    reset = 1'b1;
    @(negedge clk);
    check("mid_bclk",     32'(i2s_bclk),     32'd0);
    check("mid_lrclk",    32'(i2s_lrclk),    32'd0);
    check("mid_sdata",    32'(i2s_sdata),    32'd0);
    check("mid_ready",    32'(sample_ready), 32'd1);
    check("mid_underrun", 32'(underrun_cnt), 32'd0);
    check("mid_overrun",  32'(overrun_cnt),  32'd0);
    reset = 1'b0;
    sb.push_back(32'h0000_0000);               // frame 0 after reset
    sb.push_back(32'h0000_0000);               // frame 1: reload of zero sample
    k = 0;
    while (i2s_lrclk == 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("lr_low_after_rst", 32'(k), 32'd256);
    wait_edge(1'b1, 1'b0, t1);                 // load 1 after reset
    check("underrun_post_rst", 32'(underrun_cnt), 32'(STATS));
    check("ready_post_rst", 32'(sample_ready), 32'd1);
    wait_edge(1'b1, 1'b1, t1);
    repeat (150) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 The block SHALL have parameter BCLK_DIV, default 4, meaning clk cycles per bclk half-period (legal 2..255).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic runs on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port audio_l  input  16  signed left sample from the fmsynth output.
REQ-005 The block SHALL have port audio_r  input  16  signed right sample from the fmsynth output.
REQ-006 The block SHALL have port sample_valid  input  1  strobe qualifying audio_l/audio_r.
REQ-007 The block SHALL have port sample_ready  output  1  holding register empty, sample accepted.
REQ-008 The block SHALL have port i2s_bclk  output  1  bit clock.
REQ-009 The block SHALL have port i2s_lrclk  output  1  word select; 0 = left, 1 = right.
REQ-010 The block SHALL have port i2s_sdata  output  1  serial data, MSB first.
REQ-011 The block SHALL have port underrun_cnt  output  16  saturating count of frames with no new sample.
REQ-012 The block SHALL have port overrun_cnt  output  16  saturating count of dropped strobes.

Function
REQ-013 Frame SHALL be 64 bclk periods: 32 slots left, 32 slots right; slot bits 0-15 carry sample MSB-first, slots 16-31 drive 0.
REQ-014 i2s_bclk SHALL toggle every BCLK_DIV clk cycles; i2s_lrclk and i2s_sdata SHALL change only on the clk edge where i2s_bclk goes 1->0.
REQ-015 Standard I2S delay: sample MSB SHALL appear one bclk period after the i2s_lrclk transition of its channel.
REQ-016 Bit counter 0..63 SHALL advance on each bclk falling edge and wrap 63->0; wrap starts a new frame.
REQ-017 sample_ready SHALL be 1 when the holding register is empty; sample_valid && sample_ready SHALL capture both channels into holding and clear sample_ready next cycle.
REQ-018 sample_valid while sample_ready=0 SHALL be ignored (holding unchanged) and SHALL increment overrun_cnt.
REQ-019 One bclk before the left MSB slot (frame load point), holding SHALL transfer to shift registers and holding SHALL become empty.
REQ-020 At the load point with holding empty, shift registers SHALL reload the previous frame's sample and underrun_cnt SHALL increment.
REQ-021 sample_valid in the load-point cycle SHALL be accepted into holding after the transfer; no overrun is counted.
REQ-022 Counters SHALL saturate at 16'hFFFF.
REQ-023 Latency from accepted strobe to MSB on i2s_sdata SHALL be at most one frame plus one bclk period.

Reset
REQ-024 During reset: i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, sample_ready=1, counters=0, holding/shift/previous samples=0, bit counter=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; first frame after release starts at bit 0 and outputs zeros unless a sample is loaded.

Configuration
REQ-026 Macro AUDIO_I2S_TX_STATS_EN defined: underrun_cnt/overrun_cnt SHALL behave per REQ-018/020/022.
REQ-027 Macro undefined: both count ports SHALL be constant 0 and the counter registers SHALL not exist; all other behaviour is unchanged.

Structure
REQ-028 Shared package audio_pkg SHALL hold typedef audio_sample_t (signed 16-bit) and constants AUDIO_SLOTS_PER_CH=32, AUDIO_FRAME_BCLKS=64.
REQ-029 Bclk/lrclk generation and bit counter SHALL be sub-module audio_i2s_clkgen, providing a single-cycle falling-edge strobe, bit index and load-point strobe.

Verification
REQ-030 BCLK_DIV=4, 40 ns clk: i2s_bclk period = 320 ns, i2s_lrclk period = 20.48 us.
REQ-031 Strobe L=16'h8001, R=16'h7FFE once -> next frame sdata shows 1000_0000_0000_0001 then 16 zeros in left, 0111_1111_1111_1110 then 16 zeros in right.
REQ-032 No strobes for 3 frames after one sample -> same sample repeated each frame; underrun_cnt=3 (macro on), 0 (macro off).
REQ-033 Two strobes 1 cycle apart with holding full -> second sample dropped, overrun_cnt=1, first sample transmitted.
REQ-034 Strobe exactly at load-point cycle -> previous holding transmitted, new sample held, sample_ready=0, overrun_cnt=0.
REQ-035 Reset pulse at bit 40 -> all outputs 0 next cycle, sample_ready=1, after release lrclk low for 32 bclks.
